hier_leaf_stage: RTL and testbench
==================================

// Module: hier_leaf_stage
// PURPOSE
//  Leaf-level worker stage under a hierarchy root node; one per root child slot (slots 0..4).
//  Accepts words from the parent fan-out over a valid/ready link and buffers them in a small FIFO.
//  Emits each word tagged with the slot ID and a per-slot sequence number toward the collector.
//  A 3-state controller (IDLE/RUN/DRAIN) gates intake so a slot can be quiesced without data loss.
// PARAMETERS
//  DATA_W   16  payload width
//  DEPTH    4   FIFO entries; power of two, >=2
//  SEQ_W    8   sequence counter width; wraps modulo 2**SEQ_W
//  SLOT_ID  0   static slot index placed in the tag (0..4)
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst        in   1                  synchronous, active-high reset
//  en         in   1                  slot enable from parent
//  in_valid   in   1                  upstream word valid
//  in_data    in   DATA_W             upstream word
//  in_ready   out  1                  stage can accept
//  out_valid  out  1                  tagged word valid
//  out_data   out  3+SEQ_W+DATA_W     {SLOT_ID[2:0], seq, payload}
//  out_ready  in   1                  downstream accepts
//  level      out  $clog2(DEPTH)+1    FIFO occupancy
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, FIFO empty, seq=0.
//    Outputs: in_ready=0, out_valid=0, out_data=0, level=0, busy=0.
//  - Handshakes: push = in_valid&in_ready; pop = out_valid&out_ready.
//    out_valid/out_data hold stable until pop. in_valid may drop without acceptance.
//  - in_ready = (state==RUN) && !full; registered-free, derived from current state/count.
//  - Latency: a word accepted at cycle N into an empty FIFO shows out_valid=1 at N+1.
//  - FIFO order: strict FIFO. Head entry drives out_data.
//  - Simultaneous push/pop: level unchanged.
//    Full: in_ready=0, so no push even if pop occurs in the same cycle.
//    Empty: no pop.
//  - seq increments on each pop, wraps 2**SEQ_W-1 -> 0.
//    seq is stamped at output: the tag carries seq's value before increment.
//  - FSM:
//    IDLE  -> RUN   when en=1.
//    RUN   -> DRAIN when en=0 and level!=0.
//    RUN   -> IDLE  when en=0 and level==0.
//    DRAIN -> IDLE  when level==0, or when level==1 with a pop this cycle.
//    DRAIN -> RUN   when en=1; the re-enable takes priority.
//  - Output continues in every state while the FIFO is not empty; seq is not reset on IDLE.
//  - rst mid-transfer discards FIFO contents and seq; no partial output is emitted.
// CONFIGURATION
//  - HIER_LEAF_PARITY_EN defined:
//    extra output out_par (1 bit) = even parity (XOR) of the payload field of out_data, same cycle.
//    Reset value 0.
//  - Undefined: out_par port absent; all other behaviour identical.
// STRUCTURE
//  - Package hier_stage_pkg:
//    typedef enum logic [1:0] {IDLE, RUN, DRAIN} leaf_state_e;
//    localparam SLOT_ID_W = 3; localparam NUM_SLOTS = 5;
//    packed struct leaf_tag_t {slot, seq}.
//  - One sub-module: hier_leaf_fifo
//    sync FIFO with push/pop/full/empty/count, synchronous active-high rst.
//  - FSM, tag and sequence logic live in this top.
// TESTING
//  1 Reset with in_valid=1 held -> in_ready=0, out_valid=0, level=0, busy=0 for all reset cycles.
//  2 en=1, push 0xA5A5 at cycle N, out_ready=1 -> out_valid at N+1.
//    out_data={3'd SLOT_ID,8'h00,16'hA5A5}; next word tagged seq=8'h01.
//  3 out_ready=0, push 5 words, DEPTH=4 -> in_ready drops after the 4th push, level=4.
//    Release out_ready -> words 1..4 emerge in order, then word 5 is accepted.
//  4 Preload 256 pops, then one more -> seq tag wraps 0xFF -> 0x00.
//  5 level=3, en=0 -> state=DRAIN, in_ready=0, busy=1.
//    3 pops -> IDLE, busy=0 on the cycle after the last pop.
//    Re-assert en during DRAIN -> RUN, in_ready=1.
//  6 rst asserted with level=2 -> next cycle level=0, out_valid=0, seq restarts at 0.
//    With HIER_LEAF_PARITY_EN defined: payload 0x0001 -> out_par=1, payload 0x0003 -> out_par=0.

Source files
------------

// File: rtl/hier_stage_pkg.sv
// ---------------------------------------------------------------------------
// hier_stage_pkg
//   Shared types and constants for the hierarchy leaf stages.
//   - leaf_state_e : intake controller states (IDLE / RUN / DRAIN)
//   - SLOT_ID_W    : width of the slot field in the output tag
//   - NUM_SLOTS    : number of root child slots (0..NUM_SLOTS-1)
//   - leaf_tag_t   : {slot, seq} tag layout for the default 8-bit sequence
//   - slot_tag()   : converts an integer slot index into the tag slot field
// ---------------------------------------------------------------------------
package hier_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } leaf_state_e;

    localparam int SLOT_ID_W = 3;
    localparam int NUM_SLOTS = 5;
    localparam int TAG_SEQ_W = 8;

    typedef struct packed {
        logic [SLOT_ID_W-1:0] slot;
        logic [TAG_SEQ_W-1:0] seq;
    } leaf_tag_t;

    function automatic logic [SLOT_ID_W-1:0] slot_tag(input int id);
        return id[SLOT_ID_W-1:0];
    endfunction

endpackage

// File: rtl/hier_leaf_fifo.sv
// ---------------------------------------------------------------------------
// hier_leaf_fifo
//   Synchronous FIFO used as the intake buffer of a leaf stage.
//   Head entry is presented combinationally on rdata.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (pointers and count only)
//   push   in   write wdata (ignored when full)
//   pop    in   drop head entry (ignored when empty)
//   wdata  in   DATA_W write word
//   rdata  out  DATA_W head word (undefined content when empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module hier_leaf_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hier_leaf_stage.sv
// ---------------------------------------------------------------------------
// hier_leaf_stage
//   Leaf worker under a hierarchy root: buffers parent words in a FIFO and
//   emits them tagged {slot, seq, payload}. A 3-state controller gates intake
//   so the slot can be quiesced without losing buffered words.
// Optional feature macro: HIER_LEAF_PARITY_EN adds out_par (XOR of payload).
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   slot enable from parent
//   in_valid   in   upstream word valid
//   in_data    in   DATA_W upstream word
//   in_ready   out  stage can accept (RUN and FIFO not full)
//   out_valid  out  tagged word valid (FIFO not empty)
//   out_data   out  {SLOT_ID[2:0], seq, payload}, zero when not valid
//   out_ready  in   downstream accepts
//   level      out  FIFO occupancy
//   busy       out  controller not IDLE
//   out_par    out  (HIER_LEAF_PARITY_EN only) even parity of payload
// ---------------------------------------------------------------------------
module hier_leaf_stage
    import hier_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int SEQ_W   = 8,
    parameter int SLOT_ID = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [SLOT_ID_W+SEQ_W+DATA_W-1:0] out_data,
    input  logic                            out_ready,
    output logic [$clog2(DEPTH):0]          level,
    output logic                            busy
`ifdef HIER_LEAF_PARITY_EN
    ,
    output logic                            out_par
`endif
);

    localparam int                   LVL_W    = $clog2(DEPTH) + 1;
    localparam logic [SLOT_ID_W-1:0] SLOT_TAG = slot_tag(SLOT_ID);

    leaf_state_e       r_state;
    leaf_state_e       w_state_nxt;
    logic [SEQ_W-1:0]  r_seq;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_count;
    logic              w_push;
    logic              w_pop;

    assign in_ready  = (r_state == RUN) && !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign level     = w_count;
    assign busy      = (r_state != IDLE);

    // The tag carries the sequence value before this word's pop increments it.
    assign out_data  = out_valid ? {SLOT_TAG, r_seq, w_head} : '0;

`ifdef HIER_LEAF_PARITY_EN
    assign out_par   = ^out_data[DATA_W-1:0];
`endif

    hier_leaf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_seq <= r_seq + SEQ_W'(1);
        end
    end

    // DRAIN exits to IDLE once the last buffered word leaves; a re-enable
    // while draining returns straight to RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = RUN;
            end
            RUN: begin
                if (!en) w_state_nxt = (w_count != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (en)
                    w_state_nxt = RUN;
                else if ((w_count == '0) || ((w_count == LVL_W'(1)) && w_pop))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hier_leaf_stage.sv
module tb_hier_leaf_stage;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int SEQ_W   = 8;
    localparam int SLOT_ID = 3;
    localparam int OW      = 3 + SEQ_W + DATA_W;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [OW-1:0]     out_data;
    logic [LW-1:0]     level;
    logic              busy;
`ifdef HIER_LEAF_PARITY_EN
    logic              out_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of buffered payloads, a sequence number and a mode
    // (0 = idle, 1 = accepting, 2 = draining).
    logic [DATA_W-1:0] q[$];
    int                mseq = 0;
    int                mmode = 0;

    hier_leaf_stage #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .SEQ_W   (SEQ_W),
        .SLOT_ID (SLOT_ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .busy      (busy)
`ifdef HIER_LEAF_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_word();
        logic [OW-1:0] w;
        w = {3'(SLOT_ID), 8'(mseq), q[0]};
        return w;
    endfunction

    task automatic model_edge();
        bit pu;
        bit po;
        int lvl;
        if (rst) begin
            q.delete();
            mseq  = 0;
            mmode = 0;
        end else begin
            lvl = q.size();
            pu  = in_valid && (mmode == 1) && (lvl < DEPTH);
            po  = out_ready && (lvl > 0);
            case (mmode)
                0: if (en) mmode = 1;
                1: if (!en) mmode = (lvl != 0) ? 2 : 0;
                default: begin
                    if (en) mmode = 1;
                    else if (lvl == 0 || (lvl == 1 && po)) mmode = 0;
                end
            endcase
            if (po) begin
                void'(q.pop_front());
                mseq = (mseq + 1) % (1 << SEQ_W);
            end
            if (pu) q.push_back(in_data);
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, (mmode == 1) && (q.size() < DEPTH));
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("busy", busy, mmode != 0);
        if (q.size() > 0) chk("out_data", out_data, model_word());
`ifdef HIER_LEAF_PARITY_EN
        if (q.size() > 0) chk("out_par", out_par, ^q[0]);
        else              chk("out_par_idle", out_par, 1'b0);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [DATA_W-1:0] got[$];
        logic [7:0]        prev_seq;
        bit                have_prev;
        bit                saw_wrap;
        bit                pushed;

        // 1: reset held with in_valid asserted
        rst = 1'b1; in_valid = 1'b1; en = 1'b1; in_data = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_in_ready", in_ready, 1'b0);
            chk("t1_out_valid", out_valid, 1'b0);
            chk("t1_level", level, 0);
            chk("t1_busy", busy, 1'b0);
            chk("t1_out_data", out_data, 0);
        end
        rst = 1'b0; in_valid = 1'b0; en = 1'b0;
        cycle();

        // 2: single word latency and tag
        en = 1'b1;
        cycle();
        in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
        cycle();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_data", out_data, {3'(SLOT_ID), 8'h00, 16'hA5A5});
        in_data = 16'h1234;
        cycle();
        chk("t2_data2", out_data, {3'(SLOT_ID), 8'h01, 16'h1234});
        in_valid = 1'b0;
        cycle();

        // 3: fill past depth with output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0100 + 16'(i);
            cycle();
            if (i == 3) begin
                chk("t3_ready_full", in_ready, 1'b0);
                chk("t3_level_full", level, 4);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) got.push_back(out_data[DATA_W-1:0]);
            pushed = in_valid && in_ready;
            cycle();
            if (pushed) in_valid = 1'b0;
        end
        chk("t3_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got.size()) chk("t3_order", got[i], 16'h0100 + 16'(i));

        // 4: sequence wrap over a long stream
        have_prev = 1'b0; saw_wrap = 1'b0; prev_seq = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_data = 16'($urandom);
            if (out_valid && out_ready) begin
                if (have_prev && prev_seq == 8'hFF && out_data[23:16] == 8'h00) saw_wrap = 1'b1;
                prev_seq  = out_data[23:16];
                have_prev = 1'b1;
            end
            cycle();
        end
        chk("t4_wrap", saw_wrap, 1'b1);

        // 5: drain and re-enable
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8 && q.size() < 3; k++) cycle();
        in_valid = 1'b0;
        chk("t5_level3", level, 3);
        en = 1'b0;
        cycle();
        chk("t5_busy", busy, 1'b1);
        chk("t5_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_idle", busy, 1'b0);
        chk("t5_empty", level, 0);
        en = 1'b1; out_ready = 1'b0;
        cycle();
        in_valid = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0; en = 1'b0;
        cycle();
        chk("t5_drain_ready", in_ready, 1'b0);
        en = 1'b1;
        cycle();
        chk("t5_rerun_ready", in_ready, 1'b1);
        chk("t5_rerun_busy", busy, 1'b1);

        // 6: reset mid-transfer discards contents and sequence
        chk("t6_level2", level, 2);
        rst = 1'b1;
        cycle();
        chk("t6_level", level, 0);
        chk("t6_valid", out_valid, 1'b0);
        rst = 1'b0; en = 1'b1;
        cycle();
        in_valid = 1'b1; in_data = 16'h0001; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t6_seq", out_data[23:16], 8'h00);
        chk("t6_payload", out_data[15:0], 16'h0001);
        cycle();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
